// File: rtl/alu_unit.sv
// alu_unit: RV32I integer ALU, combinational result plus a one-cycle registered copy.
// No backpressure: alu_res/zero track inputs every cycle; alu_res_q/zero_q update on every clk edge.
module alu_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      alu_op,
  output logic [XLEN-1:0] alu_res,
  output logic            zero,
  output logic [XLEN-1:0] alu_res_q,
  output logic            zero_q
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000,
    OP_SUB  = 5'b00001,
    OP_SLL  = 5'b00010,
    OP_SLT  = 5'b00011,
    OP_SLTU = 5'b00100,
    OP_XOR  = 5'b00101,
    OP_SRL  = 5'b00110,
    OP_SRA  = 5'b00111,
    OP_OR   = 5'b01000,
    OP_AND  = 5'b01001
  } alu_op_e;

  logic [SHW-1:0] shamt;
  logic           slt_bit;
  logic           sltu_bit;

  // Only the low log2(XLEN) bits of b select the shift distance.
  assign shamt    = b[SHW-1:0];
  assign slt_bit  = $signed(a) < $signed(b);
  assign sltu_bit = a < b;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_SLL:  alu_res = a << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, slt_bit};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, sltu_bit};
      OP_XOR:  alu_res = a ^ b;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = XLEN'($signed(a) >>> shamt);
      OP_OR:   alu_res = a | b;
      OP_AND:  alu_res = a & b;
      default: alu_res = '0;
    endcase
  end

  assign zero = (alu_res == '0);

  // Reset clears only the registered copy; the combinational path keeps tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_res_q <= '0;
      zero_q    <= 1'b0;
    end else begin
      alu_res_q <= alu_res;
      zero_q    <= zero;
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed and random checks of alu_unit against an arithmetic reference model.
module tb_alu_unit;

  localparam longint unsigned TWO32 = 64'h1_0000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  alu_op;
  logic [31:0] alu_res;
  logic        zero;
  logic [31:0] alu_res_q;
  logic        zero_q;

  int tests;
  int fails;

  alu_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .alu_op    (alu_op),
    .alu_res   (alu_res),
    .zero      (zero),
    .alu_res_q (alu_res_q),
    .zero_q    (zero_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference computed with plain 64-bit arithmetic on the operand values.
  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] x,
                                          input logic [31:0] y);
    longint unsigned ux;
    longint unsigned uy;
    longint          sx;
    longint          sy;
    longint unsigned p;
    longint          q;
    int              sh;
    ux = 64'(x);
    uy = 64'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = int'(y % 32);
    p  = 1;
    for (int i = 0; i < sh; i++) p = p * 2;
    case (op)
      5'd0: return 32'((ux + uy) % TWO32);
      5'd1: return 32'((ux + TWO32 - uy) % TWO32);
      5'd2: return 32'((ux * p) % TWO32);
      5'd3: return (sx < sy) ? 32'd1 : 32'd0;
      5'd4: return (ux < uy) ? 32'd1 : 32'd0;
      5'd5: return x ^ y;
      5'd6: return 32'(ux / p);
      5'd7: begin
        q = sx / longint'(p);
        if (sx < 0 && (sx % longint'(p)) != 0) q = q - 1;
        return 32'(q);
      end
      5'd8: return x | y;
      5'd9: return x & y;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    alu_op = op;
    a      = x;
    b      = y;
    #1;
  endtask

  // Combinational check: result against model and a hand-written constant, plus zero flag.
  task automatic comb_check(input string tag, input logic [4:0] op, input logic [31:0] x,
                            input logic [31:0] y, input logic [31:0] exp);
    apply(op, x, y);
    check32({tag, "_res"}, alu_res, exp);
    check32({tag, "_model"}, alu_res, ref_alu(op, x, y));
    check1({tag, "_zero"}, zero, exp == 32'h0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [4:0]  rop;
    logic [31:0] prev_exp;
    tests  = 0;
    fails  = 0;
    rst    = 1'b1;
    a      = 32'h0;
    b      = 32'h0;
    alu_op = 5'd0;

    // Reset for two edges: registered outputs cleared even though zero is 1 combinationally.
    repeat (2) @(posedge clk);
    #1;
    check32("rst_res_q", alu_res_q, 32'h0);
    check1("rst_zero_q", zero_q, 1'b0);
    check1("rst_comb_zero", zero, 1'b1);

    comb_check("add",      5'd0, 32'h0000000A, 32'h00000003, 32'h0000000D);
    comb_check("sub",      5'd1, 32'h0000000A, 32'h00000003, 32'h00000007);
    comb_check("sub_wrap", 5'd1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF);
    comb_check("add_wrap", 5'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000);
    comb_check("sll",      5'd2, 32'h00000001, 32'h00000003, 32'h00000008);
    comb_check("srl",      5'd6, 32'h00000010, 32'h00000003, 32'h00000002);
    comb_check("sra_neg",  5'd7, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF);
    comb_check("srl_31",   5'd6, 32'h80000000, 32'h0000001F, 32'h00000001);
    comb_check("sll_b5",   5'd2, 32'h00000001, 32'h00000023, 32'h00000008);
    comb_check("sll_0",    5'd2, 32'h12345678, 32'hFFFFFFE0, 32'h12345678);
    comb_check("sra_pos",  5'd7, 32'h40000000, 32'h00000004, 32'h04000000);
    comb_check("xor",      5'd5, 32'h0000000F, 32'h000000F0, 32'h000000FF);
    comb_check("or",       5'd8, 32'h0000000F, 32'h000000F0, 32'h000000FF);
    comb_check("and",      5'd9, 32'h0000000F, 32'h000000F0, 32'h00000000);
    comb_check("slt_neg",  5'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000001);
    comb_check("sltu_big", 5'd4, 32'hFFFFFFFF, 32'h00000001, 32'h00000000);
    comb_check("sltu",     5'd4, 32'h00000001, 32'hFFFFFFFF, 32'h00000001);
    comb_check("slt_eq",   5'd3, 32'h00000005, 32'h00000005, 32'h00000000);
    comb_check("rsvd",     5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);

    // Every opcode: no X on the result, and it matches the model.
    for (int op = 0; op < 32; op++) begin
      apply(5'(op), 32'hA5A5F00F, 32'h8000000B);
      check1("sweep_noX", $isunknown(alu_res), 1'b0);
      check32("sweep_model", alu_res, ref_alu(5'(op), 32'hA5A5F00F, 32'h8000000B));
    end

    // Registered path with reset still held: comb output tracks, registers stay cleared.
    apply(5'd0, 32'h0000000A, 32'h00000003);
    check32("rst_comb_tracks", alu_res, 32'h0000000D);
    @(posedge clk);
    #1;
    check32("rst_hold_res_q", alu_res_q, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check32("reg_add", alu_res_q, 32'h0000000D);
    check1("reg_add_zero", zero_q, 1'b0);

    apply(5'd9, 32'h0000000F, 32'h000000F0);
    @(posedge clk);
    #1;
    check32("reg_and", alu_res_q, 32'h0);
    check1("reg_and_zero", zero_q, 1'b1);

    apply(5'd1, 32'h00000000, 32'h00000001);
    @(posedge clk);
    #1;
    check32("reg_sub", alu_res_q, 32'hFFFFFFFF);

    // Mid-stream reset clears only the registers.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check32("midrst_res_q", alu_res_q, 32'h0);
    check1("midrst_zero_q", zero_q, 1'b0);
    check32("midrst_comb", alu_res, 32'hFFFFFFFF);
    @(negedge clk);
    rst = 1'b0;

    // Random operands and opcodes; registered copy must equal last cycle's expectation.
    prev_exp = ref_alu(alu_op, a, b);
    for (int i = 0; i < 400; i++) begin
      ra  = $urandom;
      rb  = (i % 4 == 0) ? ra : $urandom;
      rop = 5'($urandom_range(0, (i % 8 == 0) ? 31 : 9));
      if (i % 16 == 0) ra = 32'h80000000;
      apply(rop, ra, rb);
      check32("rnd_comb", alu_res, ref_alu(rop, ra, rb));
      check1("rnd_zero", zero, ref_alu(rop, ra, rb) == 32'h0);
      @(posedge clk);
      #1;
      check32("rnd_reg", alu_res_q, ref_alu(rop, ra, rb));
      check1("rnd_reg_zero", zero_q, ref_alu(rop, ra, rb) == 32'h0);
      prev_exp = ref_alu(rop, ra, rb);
    end
    check32("final_hold", alu_res_q, prev_exp);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
